// File: rtl/gpio_pkg.sv
// Shared types and header layout for the GPIO read-out scheduler.
package gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int HDR_W        = 16;
  localparam int HDR_SEQ_LSB  = 8;
  localparam int HDR_SEQ_W    = 8;
  localparam int HDR_NV_LSB   = 6;
  localparam int HDR_NV_W     = 2;
  localparam int HDR_OVF_BIT  = 5;
  localparam int HDR_DONE_BIT = 4;

  function automatic logic [HDR_W-1:0] make_hdr(input logic [HDR_SEQ_W-1:0] seq,
                                                input logic [HDR_NV_W-1:0]  nvalid,
                                                input logic                 ovf,
                                                input logic                 done);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    h[HDR_NV_LSB +: HDR_NV_W]   = nvalid;
    h[HDR_OVF_BIT]              = ovf;
    h[HDR_DONE_BIT]             = done;
    return h;
  endfunction

endpackage

// File: rtl/gpio_readout_ctrl_if.sv
// Decoder/NPU-facing signals and GPIO outputs of the read-out scheduler.
interface gpio_readout_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 48
);
  logic              cal_start;
  logic              npu_out_data_vld;
  logic [DATA_W-1:0] npu_out_data;
  logic              rd_en;
  logic [OUT_W-1:0]  gpio_io_o;
  logic [1:0]        state_o;
  logic              overflow_o;

  modport master (
    output cal_start, npu_out_data_vld, npu_out_data, rd_en,
    input  gpio_io_o, state_o, overflow_o
  );

  modport slave (
    input  cal_start, npu_out_data_vld, npu_out_data, rd_en,
    output gpio_io_o, state_o, overflow_o
  );
endinterface

// File: rtl/gpio_result_fifo.sv
// Result FIFO: single push, pop of 0..2 entries, two combinational head taps.
module gpio_result_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic [1:0]                  pop,
  output logic [DATA_W-1:0]           head0,
  output logic [DATA_W-1:0]           head1,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Extra pointer bit distinguishes full from empty; caller guarantees
  // push only when space remains after this cycle's pop.
  assign level = wr_ptr - rd_ptr;
  assign head0 = mem[rd_ptr[AW-1:0]];
  assign head1 = mem[rd_ptr[AW-1:0] + AW'(1)];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/gpio_readout_ctrl.sv
// Captures NPU results into a FIFO and packs up to two per host read into
// a 48-bit GPIO word with a seq/nvalid/overflow/done header.
module gpio_readout_ctrl
  import gpio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RESULT_NUM = 64,
  parameter int OUT_W      = 48
) (
  input  logic         sys_clk,
  input  logic         rst,
  gpio_readout_ctrl_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [7:0]        push_cnt;
  logic [7:0]        seq;
  logic              overflow;
  logic              rd_en_d;
  logic [OUT_W-1:0]  gpio_q;

  logic [DATA_W-1:0] head0, head1, d0, d1;
  logic [LW-1:0]     level, post_pop;
  logic [1:0]        pop_n;
  logic              rd_rise, push_req, push_ok, drop, done_next;
  logic [OUT_W-1:0]  word;

  // Pop size uses the pre-push level; the full test uses the post-pop level
  // so a push into a full FIFO that is draining this cycle is kept.
  always_comb begin
    rd_rise = bus.rd_en & ~rd_en_d;
    pop_n   = 2'd0;
    if (rd_rise && !bus.cal_start)
      pop_n = (level >= LW'(2)) ? 2'd2 : level[1:0];
    post_pop  = level - LW'(pop_n);
    push_req  = bus.npu_out_data_vld && (state == ST_RUN) && !bus.cal_start;
    push_ok   = push_req && (post_pop != LW'(FIFO_DEPTH));
    drop      = push_req && !push_ok;
    done_next = (state == ST_DONE) || ((state == ST_DRAIN) && (post_pop == '0));
    d0        = (pop_n != 2'd0) ? head0 : '0;
    d1        = (pop_n == 2'd2) ? head1 : '0;
    word      = {make_hdr(seq, pop_n, overflow | drop, done_next), d1, d0};
  end

  gpio_result_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .flush     (bus.cal_start),
    .push      (push_ok),
    .push_data (bus.npu_out_data),
    .pop       (pop_n),
    .head0     (head0),
    .head1     (head1),
    .level     (level)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      push_cnt <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      rd_en_d  <= 1'b0;
      gpio_q   <= '0;
    end else begin
      rd_en_d <= bus.rd_en;
      if (bus.cal_start) begin
        state    <= ST_RUN;
        push_cnt <= '0;
        seq      <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_req) push_cnt <= push_cnt + 8'd1;
        if (drop)     overflow <= 1'b1;
        if (rd_rise) begin
          gpio_q <= word;
          if (pop_n != 2'd0) seq <= seq + 8'd1;
        end
        case (state)
          ST_RUN:   if (push_req && (push_cnt + 8'd1 == 8'(RESULT_NUM))) state <= ST_DRAIN;
          ST_DRAIN: if (post_pop == '0) state <= ST_DONE;
          default:  ;
        endcase
      end
    end
  end

  assign bus.gpio_io_o  = gpio_q;
  assign bus.state_o    = state;
  assign bus.overflow_o = overflow;
endmodule

// File: tb/tb_gpio_readout_ctrl.sv
// Bench for gpio_readout_ctrl (FIFO_DEPTH=4, RESULT_NUM=6) against a queue model.
module tb_gpio_readout_ctrl;
  localparam int DEPTH = 4;
  localparam int RNUM  = 6;

  typedef struct packed {
    logic        cal;
    logic        vld;
    logic [15:0] d;
    logic        rd;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gpio_readout_ctrl_if #(.DATA_W(16), .OUT_W(48)) bus ();

  gpio_readout_ctrl #(
    .DATA_W     (16),
    .FIFO_DEPTH (DEPTH),
    .RESULT_NUM (RNUM),
    .OUT_W      (48)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Reference model: run-level rules applied to a queue of results
  logic [15:0] m_q[$];
  int          m_push;
  int          m_seq;
  logic        m_ovf;
  logic [1:0]  m_st;
  logic [47:0] m_word;
  logic        m_rd_prev;

  function automatic void model_reset();
    m_q.delete();
    m_push = 0; m_seq = 0; m_ovf = 1'b0; m_st = 2'd0; m_word = '0; m_rd_prev = 1'b0;
  endfunction

  function automatic void model_step(logic cal, logic vld, logic [15:0] d, logic rd);
    logic        rise;
    int          n;
    logic [15:0] a, b;
    logic [1:0]  st0;
    rise = rd && !m_rd_prev;
    m_rd_prev = rd;
    if (cal) begin
      m_q.delete(); m_push = 0; m_seq = 0; m_ovf = 1'b0; m_st = 2'd1;
      return;
    end
    st0 = m_st; n = 0; a = '0; b = '0;
    if (rise) begin
      n = (m_q.size() >= 2) ? 2 : m_q.size();
      if (n >= 1) a = m_q.pop_front();
      if (n == 2) b = m_q.pop_front();
    end
    if (st0 == 2'd1 && vld) begin
      m_push++;
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
      if (m_push == RNUM) m_st = 2'd2;
    end
    if (st0 == 2'd2 && m_q.size() == 0) m_st = 2'd3;
    if (rise) begin
      m_word = {m_seq[7:0], 2'(n), m_ovf, (m_st == 2'd3), 4'b0000, b, a};
      if (n > 0) m_seq = (m_seq + 1) % 256;
    end
  endfunction

  task automatic step(input stim_t s);
    @(negedge clk);
    bus.cal_start        = s.cal;
    bus.npu_out_data_vld = s.vld;
    bus.npu_out_data     = s.d;
    bus.rd_en            = s.rd;
    model_step(s.cal, s.vld, s.d, s.rd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    rst = 1'b1;
    bus.cal_start = 1'b0; bus.npu_out_data_vld = 1'b0; bus.npu_out_data = '0; bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== 51'd0) begin
      errors++;
      $display("FAIL reset gpio=%h state=%0d ovf=%0d required all zero",
               bus.gpio_io_o, bus.state_o, bus.overflow_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    s = '{cal: 1'b0, vld: 1'b0, d: 16'h0, rd: 1'b1};
    step(s);
    s.rd = 1'b0;
    step(s);
    checks++;
    if ({bus.gpio_io_o, bus.state_o} !== {48'h000000000000, 2'b00}) begin
      errors++;
      $display("FAIL idle_read gpio=%h state=%0d required gpio=0 state=0", bus.gpio_io_o, bus.state_o);
    end
  endtask

  task automatic test_basic_run();
    stim_t sq[$];
    sq.push_back({1'b1, 1'b0, 16'h0, 1'b0});
    for (int k = 1; k <= 4; k++) sq.push_back({1'b0, 1'b1, 16'(k), 1'b0});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    sq.push_back({1'b0, 1'b1, 16'h0005, 1'b0});
    sq.push_back({1'b0, 1'b1, 16'h0006, 1'b0});
    for (int k = 0; k < 3; k++) begin
      sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
      sq.push_back({1'b0, 1'b0, 16'h0, 1'b0});
    end
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      checks++;
      if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== {m_word, m_st, m_ovf}) begin
        errors++;
        $display("FAIL basic_run cyc=%0d gpio=%h/%h state=%0d/%0d ovf=%0d/%0d", i,
                 bus.gpio_io_o, m_word, bus.state_o, m_st, bus.overflow_o, m_ovf);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t s;
    s = '{cal: 1'b1, vld: 1'b0, d: 16'h0, rd: 1'b0};
    step(s);
    s.cal = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s.vld = 1'b1; s.d = 16'(k);
      step(s);
      checks++;
      if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== {m_word, m_st, m_ovf}) begin
        errors++;
        $display("FAIL overflow_fill k=%0d gpio=%h/%h state=%0d/%0d ovf=%0d/%0d", k,
                 bus.gpio_io_o, m_word, bus.state_o, m_st, bus.overflow_o, m_ovf);
      end
    end
    checks++;
    if ({bus.state_o, bus.overflow_o} !== {2'b10, 1'b1}) begin
      errors++;
      $display("FAIL overflow_state state=%0d ovf=%0d required state=2 ovf=1", bus.state_o, bus.overflow_o);
    end
    s = '{cal: 1'b0, vld: 1'b0, d: 16'h0, rd: 1'b1};
    step(s);
    checks++;
    if (bus.gpio_io_o !== 48'h00A000020001) begin
      errors++;
      $display("FAIL overflow_word1 gpio=%h required 00a000020001", bus.gpio_io_o);
    end
    s.rd = 1'b0; step(s);
    s.rd = 1'b1; step(s);
    checks++;
    if ({bus.gpio_io_o, bus.state_o} !== {48'h01B000040003, 2'b11}) begin
      errors++;
      $display("FAIL overflow_word2 gpio=%h state=%0d required 01b000040003 state=3",
               bus.gpio_io_o, bus.state_o);
    end
    s.rd = 1'b0; step(s);
  endtask

  task automatic test_rd_held();
    stim_t sq[$];
    sq.push_back({1'b1, 1'b0, 16'h0, 1'b0});
    sq.push_back({1'b0, 1'b1, 16'hA001, 1'b0});
    sq.push_back({1'b0, 1'b1, 16'hA002, 1'b0});
    for (int k = 0; k < 20; k++) sq.push_back({1'b0, (k % 5 == 0), 16'($urandom), 1'b1});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b0});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    // full FIFO: push and read rise in the same cycle
    sq.push_back({1'b1, 1'b0, 16'h0, 1'b0});
    for (int k = 0; k < 4; k++) sq.push_back({1'b0, 1'b1, 16'(16'hB000 + k), 1'b0});
    sq.push_back({1'b0, 1'b1, 16'hB004, 1'b1});
    for (int k = 0; k < 3; k++) begin
      sq.push_back({1'b0, 1'b0, 16'h0, 1'b0});
      sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    end
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      checks++;
      if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== {m_word, m_st, m_ovf}) begin
        errors++;
        $display("FAIL rd_held cyc=%0d gpio=%h/%h state=%0d/%0d ovf=%0d/%0d", i,
                 bus.gpio_io_o, m_word, bus.state_o, m_st, bus.overflow_o, m_ovf);
      end
      if (i == 24) begin
        checks++;
        if (bus.gpio_io_o[47:40] !== 8'd1) begin
          errors++;
          $display("FAIL rd_held_once seq=%0d required 1", bus.gpio_io_o[47:40]);
        end
      end
    end
    checks++;
    if (bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop ovf=%0d required 0", bus.overflow_o);
    end
  endtask

  task automatic test_cal_mid_run();
    stim_t sq[$];
    sq.push_back({1'b1, 1'b0, 16'h0, 1'b0});
    for (int k = 0; k < 5; k++) sq.push_back({1'b0, 1'b1, 16'(16'hC000 + k), 1'b0});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b0});
    sq.push_back({1'b1, 1'b1, 16'hDEAD, 1'b1});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b0});
    sq.push_back({1'b0, 1'b0, 16'h0, 1'b1});
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      checks++;
      if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== {m_word, m_st, m_ovf}) begin
        errors++;
        $display("FAIL cal_mid cyc=%0d gpio=%h/%h state=%0d/%0d ovf=%0d/%0d", i,
                 bus.gpio_io_o, m_word, bus.state_o, m_st, bus.overflow_o, m_ovf);
      end
    end
    checks++;
    if ({bus.gpio_io_o[47:36], bus.gpio_io_o[31:0], bus.state_o, bus.overflow_o} !==
        {12'h000, 32'h0, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL cal_mid_final gpio=%h state=%0d ovf=%0d required hdr=0 data=0 state=1 ovf=0",
               bus.gpio_io_o, bus.state_o, bus.overflow_o);
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic  rd;
    rd = 1'b0;
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 250; i++) begin
        s.cal = (i == 0) || ($urandom_range(0, 60) == 0);
        s.vld = $urandom_range(0, 1) == 1;
        s.d   = 16'($urandom);
        if ($urandom_range(0, 2) == 0) rd = ~rd;
        s.rd  = rd;
        step(s);
        checks++;
        if ({bus.gpio_io_o, bus.state_o, bus.overflow_o} !== {m_word, m_st, m_ovf}) begin
          errors++;
          $display("FAIL random run=%0d cyc=%0d gpio=%h/%h state=%0d/%0d ovf=%0d/%0d", run, i,
                   bus.gpio_io_o, m_word, bus.state_o, m_st, bus.overflow_o, m_ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_overflow();
    test_rd_held();
    test_cal_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
